conv_pe_scheduler: RTL and testbench

- Controller that sequences one shared multiply-accumulate processing element (PE) through a series of convolution windows.
- Per window: clears the PE, steps an element index over all D*F*F image/filter operands, and waits for the PE pipeline to drain.
- Then captures the accumulated result and offers it downstream on a valid/ready interface.
- Sits between the layer controller (start/num_win) and the PE plus its operand-select mux.

---
 rtl/conv_pe_scheduler.sv | 148 ++++++++++++++
 tb/tb_conv_pe_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_scheduler.sv
// Sequences one shared MAC PE over a run of convolution windows:
// clear, feed D*F*F operands, drain the PE pipeline, then hand off the result.
module conv_pe_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int PE_LAT     = 3,
  parameter int CLR_CYCLES = 2,
  parameter int IDX_W      = 8,
  parameter int WIN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIN_W-1:0]      num_win,
  output logic                  busy,
  output logic                  done,
  output logic                  pe_clear,
  output logic                  operand_valid,
  output logic [IDX_W-1:0]      elem_idx,
  output logic [WIN_W-1:0]      win_idx,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);
  localparam int N     = D * F * F;
  localparam int CMAX  = (CLR_CYCLES > PE_LAT) ? CLR_CYCLES : PE_LAT;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

  // Every output lives in this register bundle so all outputs come straight from flops.
  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  clr;
    logic                  opv;
    logic [IDX_W-1:0]      idx;
    logic [WIN_W-1:0]      win;
    logic                  oval;
    logic                  olast;
    logic [DATA_WIDTH-1:0] odata;
  } regs_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIN_W-1:0] nwin, nwin_n;
  regs_t            r, r_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      nwin  <= '0;
      r     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      nwin  <= nwin_n;
      r     <= r_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nwin_n  = nwin;
    r_n     = r;
    r_n.done = 1'b0;
    r_n.clr  = 1'b0;
    r_n.opv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_win != '0) begin
            nwin_n   = num_win;
            r_n.win  = '0;
            r_n.busy = 1'b1;
            r_n.clr  = 1'b1;
            cnt_n    = '0;
            state_n  = CLEAR;
          end else begin
            r_n.done = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (cnt == CNT_W'(CLR_CYCLES - 1)) begin
          r_n.opv = 1'b1;
          r_n.idx = '0;
          state_n = FEED;
        end else begin
          r_n.clr = 1'b1;
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      FEED: begin
        if (r.idx == IDX_W'(N - 1)) begin
          r_n.idx = '0;
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          r_n.opv = 1'b1;
          r_n.idx = r.idx + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(PE_LAT - 1)) begin
          r_n.oval  = 1'b1;
          r_n.odata = pe_result;
          r_n.olast = (r.win == nwin - WIN_W'(1));
          state_n   = OUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          r_n.oval  = 1'b0;
          r_n.olast = 1'b0;
          if (r.olast) begin
            r_n.busy = 1'b0;
            r_n.done = 1'b1;
            state_n  = IDLE;
          end else begin
            r_n.win = r.win + WIN_W'(1);
            r_n.clr = 1'b1;
            cnt_n   = '0;
            state_n = CLEAR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy          = r.busy;
  assign done          = r.done;
  assign pe_clear      = r.clr;
  assign operand_valid = r.opv;
  assign elem_idx      = r.idx;
  assign win_idx       = r.win;
  assign out_valid     = r.oval;
  assign out_data      = r.odata;
  assign out_last      = r.olast;
endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Bench for conv_pe_scheduler: timeline reference model plus a PE model summing elem_idx+1.
module tb_conv_pe_scheduler;
  localparam int DW = 32, D = 1, F = 5, PL = 3, CC = 2, IW = 8, WW = 16;
  localparam int N = D * F * F;
  localparam int WIN_CYC = CC + N + PL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] num_win = '0;
  logic          out_ready = 1'b1;
  logic          busy, done, pe_clear, operand_valid, out_valid, out_last;
  logic [IW-1:0] elem_idx;
  logic [WW-1:0] win_idx;
  logic [DW-1:0] pe_result, out_data;

  conv_pe_scheduler #(
    .DATA_WIDTH(DW), .D(D), .F(F), .PE_LAT(PL), .CLR_CYCLES(CC), .IDX_W(IW), .WIN_W(WW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_win(num_win), .busy(busy), .done(done),
    .pe_clear(pe_clear), .operand_valid(operand_valid), .elem_idx(elem_idx),
    .win_idx(win_idx), .pe_result(pe_result), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PE: accumulator plus PL-1 delay stages, so pe_result trails the last operand by PL cycles.
  logic [DW-1:0] pipe [PL];
  always @(posedge clk) begin
    if (reset || pe_clear) pipe[0] <= '0;
    else if (operand_valid) pipe[0] <= pipe[0] + DW'(elem_idx) + DW'(1);
    for (int i = 1; i < PL; i++) pipe[i] <= reset ? '0 : pipe[i-1];
  end
  assign pe_result = pipe[PL-1];

  // Reference: each window is a timeline t=0.. after its start edge; result due at t=WIN_CYC.
  logic          m_act = 1'b0, m_out = 1'b0, m_last = 1'b0, m_done = 1'b0;
  logic [WW-1:0] m_win = '0, m_nwin = '0;
  int            m_t = 0;
  longint        m_data = 0;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (reset) begin
      m_act <= 1'b0; m_out <= 1'b0; m_last <= 1'b0; m_t <= 0; m_win <= '0;
    end else if (!m_act) begin
      if (start) begin
        if (num_win != 0) begin
          m_act <= 1'b1; m_nwin <= num_win; m_win <= '0; m_t <= 0;
        end else m_done <= 1'b1;
      end
    end else if (m_out) begin
      if (out_ready) begin
        m_out <= 1'b0; m_last <= 1'b0;
        if (int'(m_win) + 1 == int'(m_nwin)) begin
          m_act <= 1'b0; m_done <= 1'b1;
        end else begin
          m_win <= m_win + 1'b1; m_t <= 0;
        end
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == WIN_CYC) begin
        m_out  <= 1'b1;
        m_data <= longint'(N) * (N + 1) / 2;
        m_last <= (int'(m_win) + 1 == int'(m_nwin));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_clr, e_opv;
      e_clr = m_act && !m_out && (m_t < CC);
      e_opv = m_act && !m_out && (m_t >= CC) && (m_t < CC + N);
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("pe_clear", pe_clear, e_clr);
      chk("operand_valid", operand_valid, e_opv);
      chk("elem_idx", elem_idx, e_opv ? m_t - CC : 0);
      chk("win_idx", win_idx, m_win);
      chk("out_valid", out_valid, m_out);
      chk("out_last", out_last, m_last);
      if (m_out) chk("out_data", out_data, m_data);
      chk("clr_opv_exclusive", pe_clear && operand_valid, 0);
    end
  end

  // Result rises and done pulses, for the directed checks.
  int   rise_t[$];
  int   n_done = 0;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    prev_ov <= out_valid;
    if (out_valid === 1'b1 && !prev_ov) rise_t.push_back(cyc);
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input int nw, output int e);
    rise_t.delete();
    n_done = 0;
    num_win = WW'(nw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin tick(1); k++; end
    if (busy) chk("idle_timeout", 1, 0);
    tick(2);
  endtask

  task automatic wait_ov(input int maxc, input logic need_last);
    int k = 0;
    while (!(out_valid && (!need_last || out_last)) && k < maxc) begin tick(1); k++; end
    if (k >= maxc) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_idx(input int idx, input int maxc);
    int k = 0;
    while (!(operand_valid && int'(elem_idx) == idx) && k < maxc) begin tick(1); k++; end
    if (k >= maxc) chk("elem_idx_timeout", 0, 1);
  endtask

  initial begin
    int e;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick(1);

    // Single window: latency, sum 1..25, done after handshake.
    start_run(1, e);
    wait_ov(100, 1'b0);
    chk("t1_latency", cyc - e, 30);
    chk("t1_data", out_data, 325);
    chk("t1_last", out_last, 1);
    tick(1);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    tick(1);
    chk("t1_done_once", done, 0);

    // Three windows back-to-back.
    start_run(3, e);
    wait_idle(300);
    chk("t2_results", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      chk("t2_first", rise_t[0] - e, 30);
      chk("t2_gap1", rise_t[1] - rise_t[0], 31);
      chk("t2_gap2", rise_t[2] - rise_t[1], 31);
    end
    chk("t2_dones", n_done, 1);

    // Stall the first result for 10 cycles.
    start_run(2, e);
    wait_ov(100, 1'b0);
    out_ready = 1'b0;
    tick(10);
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_data", out_data, 325);
    chk("t3_no_clear", pe_clear, 0);
    out_ready = 1'b1;
    wait_idle(300);
    chk("t3_results", rise_t.size(), 2);
    if (rise_t.size() == 2) chk("t3_gap", rise_t[1] - rise_t[0], 41);

    // Start mid-FEED and on the final handshake are both ignored.
    start_run(2, e);
    wait_idx(5, 100);
    num_win = 7; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_ov(200, 1'b1);
    num_win = 5; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_done", done, 1);
    tick(1);
    chk("t4_busy_after", busy, 0);
    tick(3);
    chk("t4_results", rise_t.size(), 2);
    chk("t4_dones", n_done, 1);

    // Reset mid-FEED.
    start_run(1, e);
    wait_idx(12, 100);
    reset = 1'b1;
    tick(1);
    chk("t5_busy", busy, 0);
    chk("t5_opv", operand_valid, 0);
    chk("t5_idx", elem_idx, 0);
    chk("t5_done", done, 0);
    chk("t5_out_data", out_data, 0);
    reset = 1'b0;
    tick(1);
    start_run(1, e);
    wait_idx(0, 10);
    chk("t5_restart_idx", elem_idx, 0);
    wait_idle(100);
    chk("t5_results", rise_t.size(), 1);
    chk("t5_dones", n_done, 1);

    // Zero-window run.
    start_run(0, e);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    tick(1);
    chk("t6_done_once", done, 0);
    chk("t6_out_valid", out_valid, 0);

    // Random runs, ready back-pressure and stray starts; the model checks every cycle.
    for (int r = 0; r < 8; r++) begin
      start_run($urandom_range(0, 4), e);
      for (int c = 0; c < 300; c++) begin
        out_ready = ($urandom % 3) != 0;
        start = ($urandom % 16) == 0;
        num_win = WW'($urandom_range(0, 3));
        tick(1);
      end
      start = 1'b0;
      out_ready = 1'b1;
      wait_idle(800);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
